median3_stream_filter: RTL



---
 rtl/median3_stream_filter_pkg.sv | 13 +
 rtl/median3_stream_filter_median.sv | 41 ++++
 rtl/median3_stream_filter.sv | 108 ++++++++++
 3 files changed

// File: rtl/median3_stream_filter_pkg.sv
// Shared constants and state encoding for the streaming median-of-3 filter.
package median3_stream_filter_pkg;

    localparam int DW_DEF      = 4;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/median3_stream_filter_median.sv
// Combinational 3-input median finder built from magnitude comparators.
// Tie-safe: equal inputs always resolve to that shared value.
module Comparator2
    import median3_stream_filter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_gt
);

    assign o_gt = (i_a > i_b);

endmodule

module MedianFinder_3num
    import median3_stream_filter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_c,
    output logic [DW-1:0] o_med
);

    logic w_ab;
    logic w_bc;
    logic w_ac;

    Comparator2 #(.DW(DW)) u_cmp_ab (.i_a(i_a), .i_b(i_b), .o_gt(w_ab));
    Comparator2 #(.DW(DW)) u_cmp_bc (.i_a(i_b), .i_b(i_c), .o_gt(w_bc));
    Comparator2 #(.DW(DW)) u_cmp_ac (.i_a(i_a), .i_b(i_c), .o_gt(w_ac));

    // b sits between a and c when both comparisons agree; otherwise a is the
    // median exactly when it beats one neighbour but not the other.
    assign o_med = (w_ab == w_bc) ? i_b :
                   (w_ab != w_ac) ? i_a : i_c;

endmodule

// File: rtl/median3_stream_filter.sv
// Streaming median-of-3 filter with replicate padding at frame edges and a
// single registered output slot on a valid/ready handshake.
module median3_stream_filter
    import median3_stream_filter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic                   out_last,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic [DW-1:0]           r_prev;
    logic [DW-1:0]           r_cur;
    logic                    r_out_valid;
    logic [DW-1:0]           r_out_data;
    logic                    r_out_last;
    logic [FRAME_CNT_W-1:0]  r_frame_cnt;

    logic                    w_free;
    logic                    w_xfer;
    logic [DW-1:0]           w_med_c;
    logic [DW-1:0]           w_med;

    assign w_free   = !r_out_valid || out_ready;
    // rst_n is folded in so the block refuses samples while held in reset.
    assign in_ready = rst_n && w_free && (r_state != FLUSH);
    assign w_xfer   = in_valid && in_ready;

    // In FLUSH the missing right neighbour is padded by repeating cur.
    assign w_med_c = (r_state == FLUSH) ? r_cur : in_data;

    MedianFinder_3num #(.DW(DW)) u_median (
        .i_a   (r_prev),
        .i_b   (r_cur),
        .i_c   (w_med_c),
        .o_med (w_med)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prev      <= '0;
            r_cur       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_out_valid <= r_out_valid && !out_ready;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (in_last) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_data;
                            r_out_last  <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + CNT_ONE;
                        end else begin
                            r_prev  <= in_data;
                            r_cur   <= in_data;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_med;
                        r_out_last  <= 1'b0;
                        r_prev      <= r_cur;
                        r_cur       <= in_data;
                        if (in_last) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_med;
                        r_out_last  <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + CNT_ONE;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign frame_cnt = r_frame_cnt;

endmodule
